// File: rtl/i2c_pkg.sv
// Common I2C constants and the target-side state encoding.
package i2c_pkg;

  localparam logic I2C_ACK           = 1'b0;
  localparam logic I2C_NACK          = 1'b1;
  localparam int   I2C_BITS_PER_BYTE = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_tgt_state_t;

endpackage

// File: rtl/utils_pkg.sv
// Shared elaboration-time helpers for the I2C slice.
package utils;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int mclog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus stability filter for one bus line, with rise/fall flags
// derived from the filtered level.
module i2c_line_filter
  import utils::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic line_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = mclog2(FILTER_LEN);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic                   filt_reg;
  logic                   filt_next;
  logic                   filt_dly_reg;
  logic                   sync_out;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = line_i;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // The filtered level only follows the input after FILTER_LEN consecutive
  // cycles of disagreement; any shorter excursion restarts the count.
  always_comb begin
    cnt_next  = '0;
    filt_next = filt_reg;
    if (sync_out != filt_reg) begin
      if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
        filt_next = sync_out;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_reg     <= '1;
      cnt_reg      <= '0;
      filt_reg     <= 1'b1;
      filt_dly_reg <= 1'b1;
    end else begin
      sync_reg     <= sync_next;
      cnt_reg      <= cnt_next;
      filt_reg     <= filt_next;
      filt_dly_reg <= filt_reg;
    end
  end

  assign line_o = filt_reg;
  assign rise_o = filt_reg & ~filt_dly_reg;
  assign fall_o = ~filt_reg & filt_dly_reg;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: device address match, pointer byte, auto-incrementing
// register writes and reads, open-drain SDA without clock stretching.
module i2c_target
  import i2c_pkg::*;
  import utils::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h39,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  inout  wire        sda_io,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o,
  output logic       start_o,
  output logic       stop_o
);

  localparam int BIT_CNT_W = mclog2(I2C_BITS_PER_BYTE + 1);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .line_i (scl_i),
    .line_o (scl_f),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .line_i (sda_io),
    .line_o (sda_f),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_tgt_state_t       state_reg, state_next;
  logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0]           shift_reg, shift_next;
  logic                 rw_reg, rw_next;
  logic                 sda_oe_reg, sda_oe_next;
  logic [7:0]           reg_addr_reg, reg_addr_next;
  logic [7:0]           reg_wdata_reg, reg_wdata_next;
  logic                 reg_we_reg, reg_we_next;
  logic                 busy_reg, busy_next;
  logic                 start_reg, start_next;
  logic                 stop_reg, stop_next;

  logic       start_cond, stop_cond, last_bit, byte_done, rx_state;
  logic [7:0] byte_next;

  assign start_cond = sda_fall & scl_f;
  assign stop_cond  = sda_rise & scl_f;
  assign last_bit   = (bit_cnt_reg == BIT_CNT_W'(I2C_BITS_PER_BYTE - 1));
  assign byte_done  = (bit_cnt_reg == BIT_CNT_W'(I2C_BITS_PER_BYTE));
  assign byte_next  = {shift_reg[6:0], sda_f};
  assign rx_state   = (state_reg == ST_ADDR) || (state_reg == ST_PTR) || (state_reg == ST_WDATA);

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    rw_next        = rw_reg;
    sda_oe_next    = sda_oe_reg;
    reg_addr_next  = reg_addr_reg;
    reg_wdata_next = reg_wdata_reg;
    reg_we_next    = 1'b0;
    busy_next      = busy_reg;
    start_next     = 1'b0;
    stop_next      = 1'b0;

    // Post-write increment lands the cycle after the strobe.
    if (reg_we_reg) begin
      reg_addr_next = reg_addr_reg + 8'd1;
    end

    if (start_cond) begin
      state_next   = ST_ADDR;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      start_next   = 1'b1;
      busy_next    = 1'b1;
    end else if (stop_cond) begin
      state_next   = ST_IDLE;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      stop_next    = 1'b1;
      busy_next    = 1'b0;
    end else begin
      if (rx_state && scl_rise) begin
        shift_next   = byte_next;
        bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
      end

      unique case (state_reg)
        ST_ADDR: begin
          if (scl_rise && last_bit) begin
            if (byte_next[7:1] == TARGET_ADDR) begin
              rw_next    = byte_next[0];
              state_next = ST_ADDR_ACK;
            end else begin
              state_next = ST_IGNORE;
            end
          end
        end
        ST_PTR: begin
          if (scl_rise && last_bit) begin
            reg_addr_next = byte_next;
            state_next    = ST_PTR_ACK;
          end
        end
        ST_WDATA: begin
          if (scl_rise && last_bit) begin
            reg_wdata_next = byte_next;
            reg_we_next    = 1'b1;
            state_next     = ST_WDATA_ACK;
          end
        end
        // The first scl_fall in an ACK state starts driving ACK, the second
        // one (with SDA already driven) closes the slot.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_next = ~I2C_ACK;
            end else begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = '0;
              if (state_reg == ST_ADDR_ACK) begin
                if (rw_reg) begin
                  shift_next  = reg_rdata_i;
                  sda_oe_next = ~reg_rdata_i[7];
                  state_next  = ST_RDATA;
                end else begin
                  state_next = ST_PTR;
                end
              end else begin
                state_next = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
          end else if (scl_fall) begin
            if (byte_done) begin
              sda_oe_next = 1'b0;
              state_next  = ST_RDATA_ACK;
            end else begin
              shift_next  = {shift_reg[6:0], 1'b0};
              sda_oe_next = ~shift_reg[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_f == I2C_NACK) begin
              state_next = ST_IGNORE;
            end else begin
              reg_addr_next = reg_addr_reg + 8'd1;
            end
          end else if (scl_fall) begin
            shift_next   = reg_rdata_i;
            sda_oe_next  = ~reg_rdata_i[7];
            bit_cnt_next = '0;
            state_next   = ST_RDATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      rw_reg        <= 1'b0;
      sda_oe_reg    <= 1'b0;
      reg_addr_reg  <= '0;
      reg_wdata_reg <= '0;
      reg_we_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      start_reg     <= 1'b0;
      stop_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      rw_reg        <= rw_next;
      sda_oe_reg    <= sda_oe_next;
      reg_addr_reg  <= reg_addr_next;
      reg_wdata_reg <= reg_wdata_next;
      reg_we_reg    <= reg_we_next;
      busy_reg      <= busy_next;
      start_reg     <= start_next;
      stop_reg      <= stop_next;
    end
  end

  assign sda_io      = sda_oe_reg ? 1'b0 : 1'bz;
  assign reg_addr_o  = reg_addr_reg;
  assign reg_wdata_o = reg_wdata_reg;
  assign reg_we_o    = reg_we_reg;
  assign busy_o      = busy_reg;
  assign start_o     = start_reg;
  assign stop_o      = stop_reg;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C master on a pulled-up bus,
// with a write scoreboard checked by an independent monitor.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int Q = 20;  // clk cycles per quarter SCL period (8 MHz clk -> 100 kHz)

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic m_scl_low = 1'b0;
  logic m_sda_low = 1'b0;
  wire  scl_bus;
  wire  sda_bus;

  logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata_i;
  logic       reg_we_o, busy_o, start_o, stop_o;

  assign scl_bus = ~m_scl_low;
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  // Register-file model: read data is the complement of the address.
  assign reg_rdata_i = reg_addr_o ^ 8'hFF;

  i2c_target #(.TARGET_ADDR(7'h39), .SYNC_STAGES(2), .FILTER_LEN(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .scl_i       (scl_bus),
    .sda_io      (sda_bus),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_we_o    (reg_we_o),
    .reg_rdata_i (reg_rdata_i),
    .busy_o      (busy_o),
    .start_o     (start_o),
    .stop_o      (stop_o)
  );

  always #62.5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_wr_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_start  = 0;
  int  n_stop   = 0;
  int  tgt_low_cnt = 0;
  int  high_viol = 0;
  logic tgt_low_prev = 1'b0;

  // Write monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk_i) begin
    if (!rst_i && reg_we_o) begin
      wr_t e;
      n_checks++;
      if (exp_wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=0x%02h data=0x%02h, required no write",
                 reg_addr_o, reg_wdata_o);
      end else begin
        e = exp_wr_q.pop_front();
        if (reg_addr_o !== e.addr || reg_wdata_o !== e.data) begin
          n_fail++;
          $display("FAIL reg_write: got addr=0x%02h data=0x%02h, required addr=0x%02h data=0x%02h",
                   reg_addr_o, reg_wdata_o, e.addr, e.data);
        end else begin
          $display("write addr=0x%02h data=0x%02h", reg_addr_o, reg_wdata_o);
        end
      end
    end
  end

  // Bus monitor: pulses, target-driven lows, and SDA changes by the target while SCL is high.
  always @(negedge clk_i) begin
    logic tgt_low;
    tgt_low = (sda_bus === 1'b0) && !m_sda_low;
    if (start_o) n_start++;
    if (stop_o)  n_stop++;
    if (tgt_low) tgt_low_cnt++;
    if (!rst_i && scl_bus && (tgt_low != tgt_low_prev)) high_viol++;
    tgt_low_prev = tgt_low;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic bus_start();
    tick(Q); m_sda_low = 1'b0;
    tick(Q); m_scl_low = 1'b0;
    tick(Q); m_sda_low = 1'b1;
    tick(Q); m_scl_low = 1'b1;
  endtask

  task automatic bus_stop();
    tick(Q); m_sda_low = 1'b1;
    tick(Q); m_scl_low = 1'b0;
    tick(Q); m_sda_low = 1'b0;
    tick(Q);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    tick(Q); m_sda_low = ~b;
    tick(Q); m_scl_low = 1'b0;
    tick(Q);
    if (glitch) begin
      m_sda_low = 1'b1; tick(2);
      m_sda_low = 1'b0; tick(Q - 2);
    end else begin
      tick(Q);
    end
    m_scl_low = 1'b1;
  endtask

  task automatic read_bit(output logic b);
    tick(Q); m_sda_low = 1'b0;
    tick(Q); m_scl_low = 1'b0;
    tick(Q); b = sda_bus;
    tick(Q); m_scl_low = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] v, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i], i == glitch_bit);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic ack_bit);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(ack_bit, 1'b0);
  endtask

  task automatic send(input logic [7:0] v, input logic exp_ack, input string name);
    logic a;
    write_byte(v, -1, a);
    check(name, a, exp_ack);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, p0, t0;
    logic [7:0] v;
    logic a;

    tick(5);
    check("reset_addr",  reg_addr_o, 8'h00);
    check("reset_wdata", reg_wdata_o, 8'h00);
    check("reset_we",    reg_we_o, 1'b0);
    check("reset_busy",  busy_o, 1'b0);
    check("reset_start", start_o, 1'b0);
    check("reset_stop",  stop_o, 1'b0);
    check("reset_sda",   sda_bus, 1'b1);
    rst_i = 1'b0;
    tick(10);

    $display("transfer 1: write 0x10 <- AB CD");
    s0 = n_start; p0 = n_stop;
    exp_wr_q.push_back('{addr: 8'h10, data: 8'hAB});
    exp_wr_q.push_back('{addr: 8'h11, data: 8'hCD});
    bus_start();
    check("t1_busy_after_start", busy_o, 1'b1);
    send(8'h72, 1'b0, "t1_ack_addr");
    send(8'h10, 1'b0, "t1_ack_ptr");
    send(8'hAB, 1'b0, "t1_ack_d0");
    send(8'hCD, 1'b0, "t1_ack_d1");
    check("t1_busy_before_stop", busy_o, 1'b1);
    bus_stop();
    check("t1_busy_after_stop", busy_o, 1'b0);
    check("t1_start_pulses", n_start - s0, 1);
    check("t1_stop_pulses", n_stop - p0, 1);
    check("t1_writes_done", exp_wr_q.size(), 0);

    $display("transfer 2: read 2 bytes from 0x05 via repeated START");
    s0 = n_start; p0 = n_stop;
    bus_start();
    send(8'h72, 1'b0, "t2_ack_addr_w");
    send(8'h05, 1'b0, "t2_ack_ptr");
    bus_start();
    send(8'h73, 1'b0, "t2_ack_addr_r");
    read_byte(v, 1'b0);
    check("t2_rd0", v, 8'hFA);
    read_byte(v, 1'b1);
    check("t2_rd1", v, 8'hF9);
    tick(5);
    check("t2_sda_released", sda_bus, 1'b1);
    check("t2_addr_after_nack", reg_addr_o, 8'h06);
    bus_stop();
    check("t2_start_pulses", n_start - s0, 2);
    check("t2_stop_pulses", n_stop - p0, 1);

    $display("transfer 3: wrong address 0x50");
    t0 = tgt_low_cnt;
    bus_start();
    send(8'h50, 1'b1, "t3_nack_addr");
    send(8'h12, 1'b1, "t3_nack_b0");
    send(8'h34, 1'b1, "t3_nack_b1");
    send(8'h56, 1'b1, "t3_nack_b2");
    check("t3_busy_mid", busy_o, 1'b1);
    bus_stop();
    check("t3_busy_after_stop", busy_o, 1'b0);
    check("t3_never_driven", tgt_low_cnt - t0, 0);

    $display("transfer 4: pointer wrap at 0xFF");
    exp_wr_q.push_back('{addr: 8'hFF, data: 8'h01});
    exp_wr_q.push_back('{addr: 8'h00, data: 8'h02});
    bus_start();
    send(8'h72, 1'b0, "t4_ack_addr");
    send(8'hFF, 1'b0, "t4_ack_ptr");
    send(8'h01, 1'b0, "t4_ack_d0");
    send(8'h02, 1'b0, "t4_ack_d1");
    bus_stop();
    check("t4_writes_done", exp_wr_q.size(), 0);

    $display("transfer 5: STOP after 4 data bits, then write 0x20 <- 11");
    bus_start();
    send(8'h72, 1'b0, "t5_ack_addr");
    send(8'h40, 1'b0, "t5_ack_ptr");
    write_bit(1'b1, 1'b0);
    write_bit(1'b0, 1'b0);
    write_bit(1'b1, 1'b0);
    write_bit(1'b0, 1'b0);
    bus_stop();
    exp_wr_q.push_back('{addr: 8'h20, data: 8'h11});
    bus_start();
    send(8'h72, 1'b0, "t5_ack_addr2");
    send(8'h20, 1'b0, "t5_ack_ptr2");
    send(8'h11, 1'b0, "t5_ack_d0");
    bus_stop();
    check("t5_writes_done", exp_wr_q.size(), 0);

    $display("transfer 6: 2-cycle SDA glitches while SCL high");
    s0 = n_start;
    m_sda_low = 1'b1; tick(2);
    m_sda_low = 1'b0; tick(20);
    check("t6_idle_no_start", n_start - s0, 0);
    check("t6_idle_busy", busy_o, 1'b0);
    exp_wr_q.push_back('{addr: 8'h30, data: 8'hC3});
    bus_start();
    send(8'h72, 1'b0, "t6_ack_addr");
    send(8'h30, 1'b0, "t6_ack_ptr");
    write_byte(8'hC3, 7, a);
    check("t6_ack_glitched_byte", a, 1'b0);
    bus_stop();
    check("t6_start_pulses", n_start - s0, 1);
    check("t6_writes_done", exp_wr_q.size(), 0);

    $display("transfer 7: reset asserted mid-read");
    bus_start();
    send(8'h72, 1'b0, "t7_ack_addr_w");
    send(8'h80, 1'b0, "t7_ack_ptr");
    bus_start();
    send(8'h73, 1'b0, "t7_ack_addr_r");
    tick(15);
    check("t7_bit7_driven_low", sda_bus, 1'b0);
    rst_i = 1'b1;
    tick(1);
    check("t7_sda_released_by_reset", sda_bus, 1'b1);
    rst_i = 1'b0;
    tick(2);
    check("t7_busy_after_reset", busy_o, 1'b0);
    bus_stop();
    tick(10);
    check("sda_change_while_scl_high", high_viol, 0);
    check("no_pending_writes", exp_wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
